vga_title_renderer: RTL and testbench
=====================================

// Module: vga_title_renderer
// PURPOSE
//  Reader side of the 8x16 title font ROM. It converts the VGA controller's pixel
//  coordinates into font ROM addresses, consumes the ROM's 1-cycle-latency data
//  and emits a pipelined pixel_on bit that draws "Starflux" on screen.
//  It sits between the VGA sync/coordinate counter and the colour mux.
//  Blink support: a frame counter optionally toggles title visibility.
// PARAMETERS
//  TITLE_X      288  left edge of title box, in pixels
//  TITLE_Y      100  top edge of title box, in pixels
//  NUM_CHARS    8    glyph count; glyph i uses ROM code i (0..NUM_CHARS-1)
//  SCALE_LOG2   0    glyph magnification = 2**SCALE_LOG2, in both x and y
//  BLINK_FRAMES 30   frames per visible/invisible half-period (>=1)
//  X_W          10   width of pix_x
//  Y_W          9    width of pix_y
// PORTS
//  clk         in   1     system/pixel clock
//  reset       in   1     asynchronous, active-high reset
//  pix_x       in   X_W   current pixel column
//  pix_y       in   Y_W   current pixel row
//  pix_valid   in   1     pix_x/pix_y are in the active video area this cycle
//  frame_tick  in   1     one-cycle pulse per frame (start of vblank)
//  blink_en    in   1     1 = title blinks, 0 = title always visible
//  rom_add     out  11    font ROM address {code[6:0], row[3:0]}
//  rom_data    in   8     font ROM data, bit 7 = leftmost pixel of the glyph row
//  pixel_on    out  1     title pixel lit; aligned with pixel_valid
//  pixel_valid out  1     pix_valid delayed by 2 cycles
// BEHAVIOUR
//  - Reset values: pixel_on=0, pixel_valid=0, all pipeline regs=0,
//    visible=1, blink_cnt=0. rom_add is combinational.
//  - Box: dx=pix_x-TITLE_X, dy=pix_y-TITLE_Y. in_box is true when pix_valid=1,
//    0<=dx<8*NUM_CHARS<<SCALE_LOG2, and 0<=dy<16<<SCALE_LOG2.
//    Use unsigned compares with a borrow check; there is no wrap-around aliasing.
//  - Stage 0 (cycle n, combinational): sx=dx>>SCALE_LOG2, sy=dy>>SCALE_LOG2.
//    rom_add={sx[9:3] as 7b code, sy[3:0]} when in_box, else 11'h000.
//  - Edge ending cycle n: the ROM latches rom_add. The renderer latches
//    col1=sx[2:0], inbox1=in_box and valid1=pix_valid.
//  - Cycle n+1: rom_data holds the glyph row.
//    Edge ending n+1: pixel_on <= inbox1 & visible & rom_data[7-col1];
//    pixel_valid <= valid1.
//  - Total latency from pix_x/pix_y to pixel_on is exactly 2 cycles.
//    The pipeline never stalls; each cycle is independent.
//  - Blink: when blink_en=0, visible is forced to 1 and blink_cnt is held at 0.
//    When blink_en=1, each frame_tick increments blink_cnt. At
//    blink_cnt==BLINK_FRAMES-1 a frame_tick instead sets blink_cnt=0 and
//    toggles visible. visible changes only on frame_tick, never mid-frame.
//  - Simultaneous blink_en falling and frame_tick: blink_en=0 wins
//    (visible=1, cnt=0).
//  - Reset mid-line: outputs drop to 0 immediately (async). The first valid
//    pixel_on appears 2 cycles after reset deassertion with valid pix inputs.
// TESTING
//  1 Defaults, (x,y)=(288,102), pix_valid=1 -> rom_add=0x002; 2 cycles later
//    pixel_on=0 (0x7C bit7). Then (289,102) -> pixel_on=1.
//  2 (298,105) -> rom_add=0x015 ('t' row 5, data 0xFF) -> pixel_on=1 at n+2.
//    Stream x=288..351 on row y=110 and compare pixel_on against a ROM model
//    every cycle, back to back.
//  3 Edges: x=287, x=352, y=99, y=116 -> rom_add=0x000, pixel_on=0.
//    pix_valid=0 inside the box -> pixel_on=0, pixel_valid=0.
//  4 SCALE_LOG2=1, (x,y)=(290,104) -> rom_add=0x002, col 1 -> pixel_on=1.
//    Box now spans x 288..415 and y 100..131.
//  5 blink_en=1, BLINK_FRAMES=30: 30 frame_ticks -> visible=0 and in-box pixels
//    read 0; 30 more -> visible=1. Drop blink_en mid-count -> visible=1 on the
//    next cycle and cnt=0.
//  6 Assert reset during a streamed row -> pixel_on and pixel_valid go 0 at once.
//    After release, the first correct pixel appears on cycle n+2.

Source files
------------

// File: rtl/vga_title_renderer.sv
// Title text renderer: maps VGA pixel coordinates onto the 8x16 font ROM and
// produces a 2-cycle pipelined pixel_on bit with optional frame-based blinking.
module vga_title_renderer #(
   parameter int unsigned TITLE_X      = 288,
   parameter int unsigned TITLE_Y      = 100,
   parameter int unsigned NUM_CHARS    = 8,
   parameter int unsigned SCALE_LOG2   = 0,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned X_W          = 10,
   parameter int unsigned Y_W          = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [X_W-1:0] pix_x,
   input  logic [Y_W-1:0] pix_y,
   input  logic           pix_valid,
   input  logic           frame_tick,
   input  logic           blink_en,
   output logic [10:0]    rom_add,
   input  logic [7:0]     rom_data,
   output logic           pixel_on,
   output logic           pixel_valid
);

   localparam int unsigned BOX_W = (8 * NUM_CHARS) << SCALE_LOG2;
   localparam int unsigned BOX_H = 16 << SCALE_LOG2;
   localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [X_W:0]   dx_ext;
   logic [Y_W:0]   dy_ext;
   logic [X_W-1:0] dx;
   logic [Y_W-1:0] dy;
   logic [X_W-1:0] sx;
   logic [3:0]     row;
   logic [6:0]     code;
   logic           in_box;

   logic [2:0]       col1;
   logic             inbox1;
   logic             valid1;
   logic [2:0]       bit_idx;
   logic             visible;
   logic [CNT_W-1:0] blink_cnt;

   // Stage 0: box test (the extra MSB is the borrow) and ROM address
   always_comb begin
      dx_ext  = {1'b0, pix_x} - (X_W+1)'(TITLE_X);
      dy_ext  = {1'b0, pix_y} - (Y_W+1)'(TITLE_Y);
      dx      = dx_ext[X_W-1:0];
      dy      = dy_ext[Y_W-1:0];
      sx      = dx >> SCALE_LOG2;
      code    = 7'(sx >> 3);
      row     = 4'(dy >> SCALE_LOG2);
      in_box  = pix_valid && !dx_ext[X_W] && !dy_ext[Y_W] &&
                (32'(dx) < BOX_W) && (32'(dy) < BOX_H);
      rom_add = in_box ? {code, row} : 11'h000;
      bit_idx = 3'd7 - col1;
   end

   // Stage 1 registers run alongside the ROM's own address latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col1   <= '0;
         inbox1 <= 1'b0;
         valid1 <= 1'b0;
      end else begin
         col1   <= sx[2:0];
         inbox1 <= in_box;
         valid1 <= pix_valid;
      end
   end

   // Stage 2: select the glyph bit from the returned ROM row
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_on    <= 1'b0;
         pixel_valid <= 1'b0;
      end else begin
         pixel_on    <= inbox1 & visible & rom_data[bit_idx];
         pixel_valid <= valid1;
      end
   end

   // Blink state only moves on frame_tick so the title never tears mid-frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         visible   <= 1'b1;
         blink_cnt <= '0;
      end else if (!blink_en) begin
         visible   <= 1'b1;
         blink_cnt <= '0;
      end else if (frame_tick) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            visible   <= ~visible;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_title_renderer.sv
// Scoreboard bench for vga_title_renderer: default instance plus a 2x-scaled one.
module tb_vga_title_renderer;

   localparam int BF = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] pix_x = '0;
   logic [8:0] pix_y = '0;
   logic       pix_valid = 1'b0;
   logic       frame_tick = 1'b0;
   logic       blink_en = 1'b0;
   logic [10:0] rom_add0, rom_add1;
   logic [7:0]  rom_data0, rom_data1;
   logic        on0, on1, pv0, pv1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit push_en = 1'b1;

   typedef struct {
      int due;
      bit valid;
      bit lit0;
      bit lit1;
   } exp_t;
   exp_t sb[$];

   // Model blink state: visibility follows the tick count since blink was enabled
   int ticks = 0;
   bit vis_cur = 1'b1;
   bit vis_prev = 1'b1;

   vga_title_renderer u0 (
      .clk(clk), .reset(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .frame_tick(frame_tick), .blink_en(blink_en), .rom_add(rom_add0),
      .rom_data(rom_data0), .pixel_on(on0), .pixel_valid(pv0)
   );

   vga_title_renderer #(.SCALE_LOG2(1)) u1 (
      .clk(clk), .reset(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
      .frame_tick(frame_tick), .blink_en(blink_en), .rom_add(rom_add1),
      .rom_data(rom_data1), .pixel_on(on1), .pixel_valid(pv1)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] font(input int code, input int row);
      logic [7:0] v;
      if (code == 0 && row == 2) v = 8'h7C;
      else if (code == 1 && row == 5) v = 8'hFF;
      else v = 8'((code * 37 + row * 11 + 90) ^ (row * 16 + code));
      return v;
   endfunction

   // Reference: box arithmetic straight from the coordinate definitions
   task automatic ref_pix(input int x, input int y, input bit v, input int scale,
                          output logic [10:0] add, output bit lit);
      int sx, sy, code, row, col;
      logic [7:0] glyph;
      add = 11'h000;
      lit = 1'b0;
      if (v && x >= 288 && x < 288 + (64 << scale) && y >= 100 && y < 100 + (16 << scale)) begin
         sx = (x - 288) >> scale;
         sy = (y - 100) >> scale;
         code = sx / 8;
         col = sx % 8;
         row = sy % 16;
         add = 11'(code * 16 + row);
         glyph = font(code, row);
         lit = glyph[7 - col];
      end
   endtask

   // Font ROMs with one cycle of read latency
   always @(posedge clk) begin
      rom_data0 <= font(int'(rom_add0[10:4]), int'(rom_add0[3:0]));
      rom_data1 <= font(int'(rom_add1[10:4]), int'(rom_add1[3:0]));
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ticks = 0;
         vis_cur = 1'b1;
         vis_prev = 1'b1;
      end else begin
         vis_prev = vis_cur;
         if (!blink_en) ticks = 0;
         else if (frame_tick) ticks = ticks + 1;
         vis_cur = ((ticks / BF) % 2) == 0;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops entries whose output edge has just passed
   always @(negedge clk) begin
      if (!rst) begin
         while (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("pixel_valid0", int'(pv0), int'(e.valid));
            check("pixel_on0", int'(on0), int'(e.lit0 & vis_prev));
            check("pixel_valid1", int'(pv1), int'(e.valid));
            check("pixel_on1", int'(on1), int'(e.lit1 & vis_prev));
         end
      end
   end

   task automatic drive(input int x, input int y, input bit v, input bit ft, input bit be);
      logic [10:0] a0, a1;
      bit l0, l1;
      exp_t e;
      @(posedge clk);
      #1;
      pix_x = 10'(x);
      pix_y = 9'(y);
      pix_valid = v;
      frame_tick = ft;
      blink_en = be;
      ref_pix(x, y, v, 0, a0, l0);
      ref_pix(x, y, v, 1, a1, l1);
      if (push_en && !rst) begin
         e.due = cyc + 2;
         e.valid = v;
         e.lit0 = l0;
         e.lit1 = l1;
         sb.push_back(e);
      end
      #1;
      check("rom_add0", int'(rom_add0), int'(a0));
      check("rom_add1", int'(rom_add1), int'(a1));
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      #12;
      check("reset_on", int'(on0), 0);
      check("reset_valid", int'(pv0), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed points: unlit/lit neighbours, 't' row, scaled glyph, box edges
      drive(288, 102, 1, 0, 0);
      drive(289, 102, 1, 0, 0);
      drive(298, 105, 1, 0, 0);
      drive(290, 104, 1, 0, 0);
      drive(287, 102, 1, 0, 0);
      drive(352, 102, 1, 0, 0);
      drive(300, 99, 1, 0, 0);
      drive(300, 116, 1, 0, 0);
      drive(415, 131, 1, 0, 0);
      drive(416, 131, 1, 0, 0);
      drive(300, 132, 1, 0, 0);
      drive(289, 102, 0, 0, 0);

      // Back-to-back row stream
      for (int x = 288; x < 352; x++) drive(x, 110, 1, 0, 0);

      // Blink: 30 ticks hide, 30 more show, then drop enable mid-count while hidden
      for (int i = 0; i < 2 * BF; i++) begin
         drive(289, 102, 1, 1, 1);
         drive(289 + (i % 8), 102, 1, 0, 1);
      end
      for (int i = 0; i < BF + 5; i++) drive(289, 102, 1, 1, 1);
      drive(289, 102, 1, 0, 1);
      drive(289, 102, 1, 0, 0);
      drive(289, 102, 1, 0, 0);
      drive(289, 102, 1, 0, 0);

      // Randomized traffic around both boxes
      for (int i = 0; i < 600; i++) begin
         drive(270 + int'($urandom_range(0, 160)), 90 + int'($urandom_range(0, 50)),
               ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) != 0));
      end

      // Reset mid-row, then first pixel two cycles after release
      for (int x = 288; x < 300; x++) drive(x, 102, 1, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_on0", int'(on0), 0);
      check("rst_async_valid0", int'(pv0), 0);
      check("rst_async_on1", int'(on1), 0);
      check("rst_async_valid1", int'(pv1), 0);
      sb.delete();
      drive(289, 102, 1, 0, 0);
      drive(289, 102, 1, 0, 0);
      rst = 1'b0;
      drive(289, 102, 1, 0, 0);
      drive(298, 105, 1, 0, 0);
      drive(300, 300, 0, 0, 0);

      // Drain the scoreboard under a cycle budget
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
